sr_bank_driver: RTL
===================

# sr_bank_driver

Excitation driver for a bank of `WIDTH` synchronous SR flip-flops: accepts a target word over a valid/ready handshake, derives per-bit set/reset commands from a shadow copy of the bank state, and holds them for a programmable pulse width. It sits upstream of the SR flop bank and is the write-side counterpart to it. It guarantees the forbidden `s=r=1` combination is never issued. An optional readback check compares the bank output with the commanded value.

## Interface
- `WIDTH`, 8, number of SR flops driven (1..32).
- `HOLD`, 2, cycles `s_out`/`r_out` are held per transaction (>=1).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `in_valid`  in  1  target word valid.
- `in_ready`  out  1  driver can accept; `(state==IDLE) & ~reset`.
- `in_target`  in  WIDTH  desired bank contents.
- `in_force`  in  1  drive every bit regardless of shadow; sampled with `in_target`.
- `s_out`  out  WIDTH  per-bit set commands to the bank.
- `r_out`  out  WIDTH  per-bit reset commands to the bank.
- `q_fb`  in  WIDTH  bank Q readback; ignored unless verify is compiled in.
- `err_clr`  in  1  clears sticky `err`.
- `shadow`  out  WIDTH  last committed bank value.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at transaction completion.
- `err`  out  1  sticky readback mismatch flag.

## Operation
- States: IDLE, DRIVE, DONE. Reset enters IDLE.
- Accept: `in_valid & in_ready` at an edge. `in_target` and `in_force` are latched into `tgt` and `frc`.
- Excitation is registered on acceptance:
  - With `frc=0`: `s = tgt & ~shadow` and `r = ~tgt & shadow`.
  - With `frc=1`: `s = tgt` and `r = ~tgt`.
- Skip rule: if `frc=0` and `tgt==shadow`, IDLE goes directly to DONE. `s_out`/`r_out` stay 0.
- Otherwise IDLE goes to DRIVE. A hold counter loads `HOLD-1` and decrements each cycle; DRIVE goes to DONE when it reaches 0.
- DRIVE is the only state in which `s_out`/`r_out` are non-zero.
- On entering DONE:
  - `s_out`/`r_out` go to 0.
  - `shadow <= tgt`.
  - `done` pulses for that one cycle.
- DONE always goes to IDLE.
- Invariant: `s_out & r_out == 0` in every cycle.
- `err_clr` clears `err`. If `err_clr` and a new mismatch occur in the same cycle, set wins.
- Reset mid-transaction: at the next edge the state returns to IDLE, the transaction is discarded, and `shadow` goes to 0 (the bank resets to 0 together with the driver).

## Timing
- Reset values: `s_out=0`, `r_out=0`, `shadow=0`, `busy=0`, `done=0`, `err=0`. `in_ready=0` while `reset` is high and 1 in the cycle after.
- Accept at edge T:
  - DRIVE occupies cycles T+1..T+HOLD.
  - DONE and the `done` pulse occur in cycle T+HOLD+1.
  - `in_ready` returns high in cycle T+HOLD+2.
- Skip path: `done` occurs in cycle T+1 and `in_ready` returns high in T+2.
- Peak throughput: one transaction per `HOLD+2` cycles. Back-to-back `in_valid` is stalled by `in_ready`.
- `in_target`/`in_force` need only be stable in the accepting cycle.

## Configuration
- Macro: `SR_BANK_DRV_VERIFY_EN`.
- When defined:
  - In the DONE cycle, `q_fb` is compared against the just-committed `shadow`.
  - On inequality, `err` is set at the following edge and stays set until `err_clr` or `reset`.
  - The bank's registered Q is valid at that point because the last DRIVE cycle has already been clocked into it.
- When undefined: `q_fb` is unused, `err` is tied to 0, and `err_clr` is ignored. State sequencing and timing are identical.

## Test plan
- Reset with `HOLD=2`: all outputs read their reset values. Release reset and check `in_ready=1` next cycle.
- Write `0xA5` from `shadow=0x00`: check `s_out=0xA5` and `r_out=0x00` for exactly 2 cycles, then `done` pulse, `shadow=0xA5`, and `in_ready` high one cycle later.
- Write `0x0F` from `shadow=0xA5`: check `s_out=0x0A` and `r_out=0xA0`, and that `s_out & r_out` is 0 in every cycle.
- Rewrite `0x0F` with `in_force=0`: no DRIVE cycles, `s_out`/`r_out` stay 0, `done` in T+1. Rewrite `0x0F` with `in_force=1`: check `s_out=0x0F` and `r_out=0xF0` for 2 cycles.
- With `SR_BANK_DRV_VERIFY_EN`: write `0x3C` with `q_fb=0x3D` in the DONE cycle; check `err=1` next cycle and that it stays set. Pulse `err_clr` and check `err=0`. Without the macro, check `err` stays 0.
- Assert `reset` in the first DRIVE cycle of a `0xFF` write: next cycle `s_out=0`, `r_out=0`, `shadow=0`, `busy=0`, and no `done` pulse.

Source files
------------

// File: rtl/sr_bank_driver.sv
// rtl/sr_bank_driver.sv - set/reset excitation driver for a bank of SR flip-flops
//
// Takes a target word through a valid/ready handshake. It compares the word with a
// shadow copy of the bank and turns the difference into per-bit set and reset
// commands. Those commands are held for HOLD cycles and then dropped. The shadow is
// updated only when the transaction completes.
//
// Parameters:
//   WIDTH  number of SR flops driven (1..32)
//   HOLD   cycles s_out/r_out are held per transaction (>=1)
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     target word handshake
//   in_target, in_force   target word; force drives every bit regardless of shadow
//   s_out, r_out          per-bit set/reset commands (never both high on one bit)
//   q_fb                  bank Q readback (used only with SR_BANK_DRV_VERIFY_EN)
//   err_clr               clears sticky err
//   shadow                last committed bank value
//   busy, done            not-idle flag; one-cycle completion pulse
//   err                   sticky readback mismatch flag
//
// Optional feature macro: SR_BANK_DRV_VERIFY_EN enables the readback check that drives err.

module sr_bank_driver #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic             in_force,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             err_clr,
    output logic [WIDTH-1:0] shadow,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] shadow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tgt      <= '0;
            s_q      <= '0;
            r_q      <= '0;
            shadow_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // When reset is low, in_ready is simply state==IDLE.
                    if (in_valid) begin
                        tgt <= in_target;
                        if (!in_force && (in_target == shadow_q)) begin
                            // The bank already holds the target, so no excitation is needed.
                            state    <= ST_DONE;
                            shadow_q <= in_target;
                        end else begin
                            state <= ST_DRIVE;
                            cnt   <= CW'(HOLD - 1);
                            // Each bit's s and r are complements of in_target, or
                            // masked complements of it. This makes s=r=1 impossible.
                            s_q   <= in_force ? in_target  : (in_target & ~shadow_q);
                            r_q   <= in_force ? ~in_target : (~in_target & shadow_q);
                        end
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        state    <= ST_DONE;
                        s_q      <= '0;
                        r_q      <= '0;
                        shadow_q <= tgt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state == ST_IDLE) & ~reset;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign s_out    = s_q;
    assign r_out    = r_q;
    assign shadow   = shadow_q;

`ifdef SR_BANK_DRV_VERIFY_EN
    logic err_q;

    // In the DONE cycle the bank has already clocked in the last DRIVE command.
    // Its Q must therefore equal the newly committed shadow. A new mismatch wins
    // over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state == ST_DONE) && (q_fb != shadow_q)) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_fb;
    assign unused_fb = &{1'b0, q_fb, err_clr};
    assign err       = 1'b0;
`endif

endmodule
